wisc_pipe_ctrl: RTL and testbench

Pipelined control unit for the 16-bit WISC core. It decodes the 4-bit opcode in ID into a control bundle and carries it through EX, MEM and WB registers. It also generates the load-use interlock, multi-cycle memory stalls and the HLT drain/halt sequence, and drives PC/IF-ID freeze and per-stage valid qualifiers.

---
 rtl/wisc_pipe_ctrl_if.sv | 41 ++++
 rtl/wisc_pipe_ctrl.sv | 141 ++++++++++++++
 tb/tb_wisc_pipe_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wisc_pipe_ctrl_if.sv
// ID-side inputs and per-stage control outputs of wisc_pipe_ctrl.
// master = datapath side, slave = control unit.
interface wisc_pipe_ctrl_if #(
    parameter int RIDX_W = 4
);
    logic              id_valid;
    logic [3:0]        id_opcode;
    logic [RIDX_W-1:0] id_src1;
    logic [RIDX_W-1:0] id_src2;
    logic [RIDX_W-1:0] id_dst;
    logic              flush_id;
    logic              pc_stall;
    logic              id_bubble;
    logic              mem_busy;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [14:0]       ex_ctrl;
    logic [14:0]       mem_ctrl;
    logic [14:0]       wb_ctrl;
    logic [RIDX_W-1:0] ex_dst;
    logic [RIDX_W-1:0] mem_dst;
    logic [RIDX_W-1:0] wb_dst;
    logic              halted;

    modport master (
        output id_valid, id_opcode, id_src1, id_src2, id_dst, flush_id,
        input  pc_stall, id_bubble, mem_busy,
        input  ex_valid, mem_valid, wb_valid,
        input  ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_dst, mem_dst, wb_dst, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_src1, id_src2, id_dst, flush_id,
        output pc_stall, id_bubble, mem_busy,
        output ex_valid, mem_valid, wb_valid,
        output ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_dst, mem_dst, wb_dst, halted
    );
endinterface

// File: rtl/wisc_pipe_ctrl.sv
// WISC pipelined control: decode, EX/MEM/WB control regs, stalls, halt.
// Define WISC_LOADUSE_EN to enable the hardware load-use interlock.
module wisc_pipe_ctrl #(
    parameter int RIDX_W  = 4,
    parameter int MEM_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    wisc_pipe_ctrl_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic MULTI = (MEM_LAT > 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state;
    logic              halted;
    logic [CNT_W-1:0]  cnt;
    logic              ex_valid, mem_valid, wb_valid;
    logic [14:0]       ex_ctrl, mem_ctrl, wb_ctrl;
    logic [RIDX_W-1:0] ex_dst, mem_dst, wb_dst;

    logic              id_live;
    logic              mem_stall;
    logic              hazard;
    logic              bubble;
    logic              take_id;
    logic [14:0]       id_ctrl;

    function automatic logic [14:0] decode(input logic [3:0] op);
        logic [10:0] b;
        unique case (op)
            4'h0, 4'h1:             b = 11'h103;
            4'h2:                   b = 11'h102;
            4'h3, 4'h7:             b = 11'h100;
            4'h4, 4'h5, 4'h6:       b = 11'h502;
            4'h8:                   b = 11'h740;
            4'h9:                   b = 11'h460;
            4'hA, 4'hB:             b = 11'h580;
            4'hC, 4'hD:             b = 11'h010;
            4'hE:                   b = 11'h108;
            default:                b = 11'h004;
        endcase
        return {op, b};
    endfunction

    assign id_ctrl   = decode(bus.id_opcode);
    assign id_live   = bus.id_valid & (state == RUN);
    assign mem_stall = MULTI & mem_valid & mem_ctrl[6] & (cnt < CNT_LAST);

`ifdef WISC_LOADUSE_EN
    logic use1, use2, hit1, hit2;
    assign use1 = !(bus.id_opcode inside {4'hC, 4'hE, 4'hF});
    assign use2 = bus.id_opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9};
    assign hit1 = use1 & (bus.id_src1 == ex_dst);
    assign hit2 = use2 & (bus.id_src2 == ex_dst);
    assign hazard = ex_valid & ex_ctrl[9] & (ex_dst != '0) & id_live
                  & (hit1 | hit2);
`else
    assign hazard = 1'b0;
`endif

    assign bubble  = hazard & ~mem_stall & ~bus.flush_id;
    assign take_id = id_live & ~bus.flush_id & ~hazard;

    assign bus.id_bubble = bubble;
    assign bus.mem_busy  = mem_stall;
    assign bus.pc_stall  = mem_stall | bubble | (state != RUN);
    assign bus.ex_valid  = ex_valid;
    assign bus.mem_valid = mem_valid;
    assign bus.wb_valid  = wb_valid;
    assign bus.ex_ctrl   = ex_ctrl;
    assign bus.mem_ctrl  = mem_ctrl;
    assign bus.wb_ctrl   = wb_ctrl;
    assign bus.ex_dst    = ex_dst;
    assign bus.mem_dst   = mem_dst;
    assign bus.wb_dst    = wb_dst;
    assign bus.halted    = halted;

    // Stage registers: hold EX/MEM during a memory stall, else advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_dst    <= '0;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dst   <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_dst    <= '0;
        end else if (mem_stall) begin
            cnt      <= cnt + 1'b1;
            wb_valid <= 1'b0;
            wb_ctrl  <= '0;
            wb_dst   <= '0;
        end else begin
            cnt       <= '0;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dst    <= mem_dst;
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_dst   <= ex_dst;
            if (take_id) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
                ex_dst   <= bus.id_dst;
            end else begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_dst   <= '0;
            end
        end
    end

    // Halt sequencing: HLT entering EX drains, HLT reaching WB halts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!mem_stall && take_id && bus.id_opcode == 4'hF)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (wb_valid && wb_ctrl[2]) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_wisc_pipe_ctrl.sv
// Self-checking bench for wisc_pipe_ctrl: directed steps plus random
// instruction streams compared against a cycle-level pipeline model.
module tb_wisc_pipe_ctrl;
    localparam int RW  = 4;
    localparam int LAT = 4;
`ifdef WISC_LOADUSE_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic [14:0] c;
        logic [3:0]  d;
    } stg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wisc_pipe_ctrl_if #(.RIDX_W(RW)) bus ();

    wisc_pipe_ctrl #(.RIDX_W(RW), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    stg_t m_ex, m_mem, m_wb;
    int   m_age;
    int   m_mode;
    bit   last_stall;

    logic       cur_v, cur_fl;
    logic [3:0] cur_op, cur_s1, cur_s2, cur_d;

    int nbusy, nwb;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [14:0] ref_ctrl(input logic [3:0] op);
        int o;
        logic [14:0] c;
        o = int'(op);
        c[14:11] = op;
        c[10] = o inside {[4:6], [8:11]};
        c[9]  = (o == 8);
        c[8]  = o inside {[0:8], 10, 11, 14};
        c[7]  = o inside {10, 11};
        c[6]  = o inside {8, 9};
        c[5]  = (o == 9);
        c[4]  = o inside {12, 13};
        c[3]  = (o == 14);
        c[2]  = (o == 15);
        c[1]  = o inside {[0:2], [4:6]};
        c[0]  = o inside {0, 1};
        return c;
    endfunction

    function automatic bit rd1(input logic [3:0] op);
        return !(int'(op) inside {12, 14, 15});
    endfunction

    function automatic bit rd2(input logic [3:0] op);
        return int'(op) inside {[0:3], 7, 9};
    endfunction

    function automatic bit model_busy();
        return m_mem.v && m_mem.c[6] && (LAT > 1) && (m_age < LAT - 1);
    endfunction

    task automatic model_reset();
        m_ex = '0;
        m_mem = '0;
        m_wb = '0;
        m_age = 0;
        m_mode = 0;
        last_stall = 1'b0;
    endtask

    task automatic drive();
        bus.id_valid  = cur_v;
        bus.id_opcode = cur_op;
        bus.id_src1   = cur_s1;
        bus.id_src2   = cur_s2;
        bus.id_dst    = cur_d;
        bus.flush_id  = cur_fl;
    endtask

    task automatic check_all(input logic b, input logic bb, input logic st);
        chk("mem_busy", 32'(bus.mem_busy), 32'(b));
        chk("id_bubble", 32'(bus.id_bubble), 32'(bb));
        chk("pc_stall", 32'(bus.pc_stall), 32'(st));
        chk("ex_stage", 32'({bus.ex_valid, bus.ex_ctrl, bus.ex_dst}),
            32'(m_ex));
        chk("mem_stage", 32'({bus.mem_valid, bus.mem_ctrl, bus.mem_dst}),
            32'(m_mem));
        chk("wb_stage", 32'({bus.wb_valid, bus.wb_ctrl, bus.wb_dst}),
            32'(m_wb));
        chk("halted", 32'(bus.halted), 32'(m_mode == 2));
    endtask

    task automatic step();
        logic busy, live, hz, bub, stall;
        @(negedge clk);
        drive();
        #1;
        busy = model_busy();
        live = cur_v && (m_mode == 0);
        hz = 1'b0;
`ifdef WISC_LOADUSE_EN
        if (m_ex.v && m_ex.c[9] && m_ex.d != 4'd0 && live)
            hz = (rd1(cur_op) && cur_s1 == m_ex.d)
              || (rd2(cur_op) && cur_s2 == m_ex.d);
`endif
        bub = hz && !busy && !cur_fl;
        stall = busy || bub || (m_mode != 0);
        check_all(busy, bub, stall);
        cyc++;
        if (m_mode == 1 && m_wb.v && m_wb.c[2]) m_mode = 2;
        if (busy) begin
            m_age++;
            m_wb = '0;
        end else begin
            m_age = 0;
            m_wb = m_mem;
            m_mem = m_ex;
            if (live && !cur_fl && !hz) begin
                m_ex = {1'b1, ref_ctrl(cur_op), cur_d};
                if (cur_op == 4'hF) m_mode = 1;
            end else begin
                m_ex = '0;
            end
        end
        last_stall = stall;
    endtask

    task automatic instr(input logic v, input logic [3:0] op,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic fl);
        cur_v = v;
        cur_op = op;
        cur_s1 = s1;
        cur_s2 = s2;
        cur_d = d;
        cur_fl = fl;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) instr(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cur_v = 1'b0;
        cur_fl = 1'b0;
        drive();
        #1;
        model_reset();
        check_all(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle(input bit allow_hlt);
        if (!last_stall) begin
            cur_v = ($urandom_range(0, 9) < 8);
            if (allow_hlt && $urandom_range(0, 39) == 0)
                cur_op = 4'hF;
            else
                cur_op = 4'($urandom_range(0, 14));
            cur_s1 = 4'($urandom_range(0, 3));
            cur_s2 = 4'($urandom_range(0, 3));
            cur_d = 4'($urandom_range(0, 3));
        end
        cur_fl = 1'b0;
        if (!model_busy() && m_mode == 0 && $urandom_range(0, 9) == 0)
            cur_fl = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cur_v = 1'b0;
        cur_op = 4'h0;
        cur_s1 = 4'h0;
        cur_s2 = 4'h0;
        cur_d = 4'h0;
        cur_fl = 1'b0;
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // ADD through the pipe
        instr(1'b1, 4'h0, 4'h1, 4'h2, 4'h5, 1'b0);
        @(posedge clk);
        #1;
        chk("add_ex_ctrl", 32'(bus.ex_ctrl), 32'h0103);
        idle(2);
        @(posedge clk);
        #1;
        chk("add_wb_valid", 32'(bus.wb_valid), 32'h1);
        chk("add_wb_ctrl", 32'(bus.wb_ctrl), 32'h0103);
        idle(2);

        // load-use with dst=3, then dst=0
        instr(1'b1, 4'h8, 4'h1, 4'h0, 4'h3, 1'b0);
        instr(1'b1, 4'h0, 4'h3, 4'h2, 4'h4, 1'b0);
        chk("lu_bubble", 32'(bus.id_bubble), 32'(LU));
        chk("lu_stall", 32'(bus.pc_stall), 32'(LU));
        instr(1'b1, 4'h0, 4'h3, 4'h2, 4'h4, 1'b0);
        idle(8);
        instr(1'b1, 4'h8, 4'h1, 4'h0, 4'h0, 1'b0);
        instr(1'b1, 4'h0, 4'h0, 4'h2, 4'h4, 1'b0);
        chk("lu_dst0", 32'(bus.id_bubble), 32'h0);
        idle(8);

        // SW multi-cycle memory access
        instr(1'b1, 4'h9, 4'h1, 4'h2, 4'h0, 1'b0);
        nbusy = 0;
        nwb = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            nbusy += int'(bus.mem_busy);
            if (bus.wb_valid && bus.wb_ctrl == 15'h4C60) nwb++;
        end
        chk("sw_busy_cycles", 32'(nbusy), 32'(LAT - 1));
        chk("sw_wb_once", 32'(nwb), 32'h1);

        // branch, load, then flushed dependent instruction
        instr(1'b1, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0);
        instr(1'b1, 4'h8, 4'h1, 4'h0, 4'h3, 1'b0);
        instr(1'b1, 4'h0, 4'h3, 4'h3, 4'h4, 1'b1);
        chk("flush_bubble", 32'(bus.id_bubble), 32'h0);
        @(posedge clk);
        #1;
        chk("flush_ex", 32'(bus.ex_valid), 32'h0);
        idle(8);

        // HLT drain, halt and reset
        instr(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("hlt_stall", 32'(bus.pc_stall), 32'h1);
        idle(6);
        chk("halted_set", 32'(bus.halted), 32'h1);
        instr(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0);
        idle(2);
        chk("halted_sticky", 32'(bus.halted), 32'h1);
        do_reset();
        chk("halted_cleared", 32'(bus.halted), 32'h0);

        // reset while the memory counter is at 2
        instr(1'b1, 4'h8, 4'h1, 4'h0, 4'h1, 1'b0);
        idle(3);
        do_reset();
        instr(1'b1, 4'h8, 4'h1, 4'h0, 4'h2, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            nbusy += int'(bus.mem_busy);
        end
        chk("post_rst_busy", 32'(nbusy), 32'(LAT - 1));

        // random streams, first without HLT, then with
        for (int i = 0; i < 300; i++) rand_cycle(1'b0);
        do_reset();
        for (int i = 0; i < 200; i++) rand_cycle(1'b1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
